// File: rtl/logic_pkg.sv
// Shared opcode and state encodings for the shared bitwise logic unit.
package logic_pkg;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    // Walk from farthest to nearest so the candidate closest to ptr_i wins last.
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % int'(NREQ);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = IDW'(cand);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// One 32-bit bitwise logic unit shared round-robin between NREQ requesters,
// with a single registered valid/ready result tagged by requester index.
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic [NREQ*2-1:0]     req_op_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic                  busy_o
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;

  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     win;
  logic               any_gnt;
  logic               can_accept;
  logic               accept;
  logic [1:0]         win_op;
  logic [WIDTH-1:0]   win_a, win_b, result;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any_gnt)
  );

  assign can_accept = (state_q == ST_EMPTY) || rsp_ready_i;
  assign accept     = any_gnt && can_accept;

  assign win_a  = req_a_i[int'(win)*WIDTH +: WIDTH];
  assign win_b  = req_b_i[int'(win)*WIDTH +: WIDTH];
  assign win_op = req_op_i[int'(win)*2 +: 2];

  always_comb begin
    result = '0;
    unique case (win_op)
      OP_AND:  result = win_a & win_b;
      OP_OR:   result = win_a | win_b;
      OP_XOR:  result = win_a ^ win_b;
      OP_PASS: result = win_a;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = result;
      id_d    = win;
      ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end else if (state_q == ST_FULL && rsp_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  // Grants are suppressed during reset so no requester believes it was accepted.
  assign req_ready_o = (accept && !reset_i) ? gnt : '0;
  assign rsp_valid_o = (state_q == ST_FULL);
  assign rsp_data_o  = data_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = rsp_valid_o || (|req_valid_i);

endmodule
